// File: rtl/radio_write_if.sv
// Maze-update / radio handshake bundle for radio_write.
// slave: the radio_write block; master: whoever feeds updates and acks packets.
interface radio_write_if;
  logic [2:0] in_x;
  logic [1:0] in_y;
  logic [1:0] in_value;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] data_out;
  logic       data_valid;
  logic       data_ack;
  logic       tx_fail;
  logic       dup_drop;
  logic       busy;

  modport slave (
    input  in_x, in_y, in_value, in_valid, data_ack,
    output in_ready, data_out, data_valid, tx_fail, dup_drop, busy
  );

  modport master (
    output in_x, in_y, in_value, in_valid, data_ack,
    input  in_ready, data_out, data_valid, tx_fail, dup_drop, busy
  );
endinterface

// File: rtl/radio_write.sv
// radio_write: queues maze-cell updates and ships each one as a 7-bit packet
// {X,Y,VALUE} over a valid/ack link, with an ack timeout and an inter-packet gap.
// Optional macro RADIO_WRITE_DEDUP_EN: drop a popped packet equal to the last
// acknowledged one instead of sending it.
module radio_write #(
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 255,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  radio_write_if.slave   bus
);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [6:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [7:0]      wait_q, wait_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [6:0]      dout_q, dout_d;
  logic            dv_q, dv_d;
  logic            txf_q, txf_d;
  logic            dup_q, dup_d;
  logic            ack_ok;
  logic            dup_hit;

  logic            full, empty, push, pop;
  logic [6:0]      head;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  // Readiness ignores a same-cycle pop so the accept path stays shallow.
  assign push  = bus.in_valid && !full;
  // Every pop in IDLE either launches a SEND or (with dedup) is discarded.
  assign pop   = (state_q == S_IDLE) && !empty;

  assign bus.in_ready   = !full;
  assign bus.data_out   = dout_q;
  assign bus.data_valid = dv_q;
  assign bus.tx_fail    = txf_q;
  assign bus.dup_drop   = dup_q;
  assign bus.busy       = (state_q != S_IDLE) || !empty;

`ifdef RADIO_WRITE_DEDUP_EN
  logic [6:0] last_q;
  logic       last_vld_q;

  assign dup_hit = last_vld_q && (head == last_q);

  // Remember the most recent packet the radio actually acknowledged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (ack_ok) begin
      last_q     <= dout_q;
      last_vld_q <= 1'b1;
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  // Queue storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {bus.in_x, bus.in_y, bus.in_value};
  end

  // Queue pointers and occupancy; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      gap_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      txf_q   <= 1'b0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      gap_q   <= gap_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      txf_q   <= txf_d;
      dup_q   <= dup_d;
    end
  end

  // Next state: launch from the queue, hold until ack/timeout, then pace with GAP.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    gap_d   = gap_q;
    dout_d  = dout_q;
    dv_d    = dv_q;
    txf_d   = 1'b0;
    dup_d   = 1'b0;
    ack_ok  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          if (dup_hit) begin
            dup_d = 1'b1;
          end else begin
            dout_d  = head;
            dv_d    = 1'b1;
            wait_d  = '0;
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        // An ack on the expiry cycle still wins over the timeout.
        if (bus.data_ack || wait_q == 8'(TIMEOUT - 1)) begin
          dv_d    = 1'b0;
          ack_ok  = bus.data_ack;
          txf_d   = !bus.data_ack;
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_LAST)) state_d = S_IDLE;
        else                        gap_d   = gap_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_radio_write.sv
// Directed bench for radio_write: main instance GAP=2/TIMEOUT=8/DEPTH=4,
// second instance GAP=0 for back-to-back pacing.
module tb_radio_write;
  logic clk, rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  radio_write_if b0 ();
  radio_write_if b1 ();

  radio_write #(.GAP_CYCLES(2), .TIMEOUT(8), .FIFO_DEPTH(4)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(b0));
  radio_write #(.GAP_CYCLES(0), .TIMEOUT(8), .FIFO_DEPTH(4)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive0(logic [6:0] p);
    {b0.in_x, b0.in_y, b0.in_value} = p;
    b0.in_valid = 1'b1;
  endtask

  task automatic drive1(logic [6:0] p);
    {b1.in_x, b1.in_y, b1.in_value} = p;
    b1.in_valid = 1'b1;
  endtask

  // Tick until DATA_VALID on instance 0, bounded; expiry is a failed check.
  task automatic wait_dv0(int max);
    int n = 0;
    while (!b0.data_valid && n < max) begin
      tick();
      n++;
    end
    check("wait_dv", {7'b0, b0.data_valid}, 8'd1);
  endtask

  task automatic ack0();
    b0.data_ack = 1'b1;
    tick();
    b0.data_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    b0.in_x = '0; b0.in_y = '0; b0.in_value = '0; b0.in_valid = 1'b0; b0.data_ack = 1'b0;
    b1.in_x = '0; b1.in_y = '0; b1.in_value = '0; b1.in_valid = 1'b0; b1.data_ack = 1'b0;
    #1;
    // Reset state
    check("rst_dv",    {7'b0, b0.data_valid}, 8'd0);
    check("rst_dout",  {1'b0, b0.data_out},   8'd0);
    check("rst_ready", {7'b0, b0.in_ready},   8'd1);
    check("rst_busy",  {7'b0, b0.busy},       8'd0);
    check("rst_txf",   {7'b0, b0.tx_fail},    8'd0);
    check("rst_dup",   {7'b0, b0.dup_drop},   8'd0);
    tick();
    rst_n = 1'b1;

    // Single update X=5,Y=2,V=3, acked one cycle after DATA_VALID
    drive0(7'h5B);
    tick();
    b0.in_valid = 1'b0;
    check("t1_dv_k",    {7'b0, b0.data_valid}, 8'd0);
    check("t1_busy_k",  {7'b0, b0.busy},       8'd1);
    check("t1_ready_k", {7'b0, b0.in_ready},   8'd1);
    tick();
    check("t1_dv_k1",   {7'b0, b0.data_valid}, 8'd1);
    check("t1_dout",    {1'b0, b0.data_out},   8'h5B);
    ack0();
    check("t1_dv_ack",  {7'b0, b0.data_valid}, 8'd0);
    check("t1_hold",    {1'b0, b0.data_out},   8'h5B);
    check("t1_busy_gap",{7'b0, b0.busy},       8'd1);
    tick();
    tick();
    check("t1_idle",    {7'b0, b0.busy},       8'd0);

    // Timeout: A never acked, B queued behind it
    drive0(7'h05);
    tick();
    drive0(7'h4A);
    tick();
    b0.in_valid = 1'b0;
    check("t2_dv_on",   {7'b0, b0.data_valid}, 8'd1);
    check("t2_dout_a",  {1'b0, b0.data_out},   8'h05);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("t2_dv_hold", {7'b0, b0.data_valid}, 8'd1);
    end
    tick();
    check("t2_dv_off",  {7'b0, b0.data_valid}, 8'd0);
    check("t2_txf_on",  {7'b0, b0.tx_fail},    8'd1);
    tick();
    check("t2_txf_off", {7'b0, b0.tx_fail},    8'd0);
    check("t2_keep_a",  {1'b0, b0.data_out},   8'h05);
    check("t2_gap2",    {7'b0, b0.data_valid}, 8'd0);
    tick();
    check("t2_idle",    {7'b0, b0.data_valid}, 8'd0);
    tick();
    check("t2_dv_b",    {7'b0, b0.data_valid}, 8'd1);
    check("t2_dout_b",  {1'b0, b0.data_out},   8'h4A);
    ack0();
    check("t2_b_ok",    {7'b0, b0.tx_fail},    8'd0);
    tick();
    tick();
    check("t2_done",    {7'b0, b0.busy},       8'd0);

    // Fill: six back-to-back offers with no ack; sixth is rejected
    for (int i = 0; i < 6; i++) begin
      drive0(7'h11 + 7'(i));
      tick();
      if (i == 4) check("t3_full", {7'b0, b0.in_ready}, 8'd0);
    end
    b0.in_valid = 1'b0;
    check("t3_still_full", {7'b0, b0.in_ready}, 8'd0);
    check("t3_dout_p0",    {1'b0, b0.data_out}, 8'h11);
    ack0();
    for (int i = 1; i < 5; i++) begin
      wait_dv0(8);
      check("t3_dout", {1'b0, b0.data_out}, 8'h11 + 8'(i));
      check("t3_ready", {7'b0, b0.in_ready}, 8'd1);
      ack0();
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_no_p5", {7'b0, b0.data_valid}, 8'd0);
    end
    check("t3_empty", {7'b0, b0.busy}, 8'd0);

    // Reset during SEND with three queued
    for (int i = 0; i < 4; i++) begin
      drive0(7'h21 + 7'(i));
      tick();
    end
    b0.in_valid = 1'b0;
    check("t4_sending", {7'b0, b0.data_valid}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_dv_async", {7'b0, b0.data_valid}, 8'd0);
    check("t4_busy",     {7'b0, b0.busy},       8'd0);
    check("t4_ready",    {7'b0, b0.in_ready},   8'd1);
    check("t4_txf",      {7'b0, b0.tx_fail},    8'd0);
    check("t4_dout",     {1'b0, b0.data_out},   8'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("t4_post_dv",  {7'b0, b0.data_valid}, 8'd0);
    check("t4_post_txf", {7'b0, b0.tx_fail},    8'd0);
    check("t4_post_busy",{7'b0, b0.busy},       8'd0);

    // Duplicate handling: send/ack 2D, offer 2D again, then 2E
    drive0(7'h2D);
    tick();
    b0.in_valid = 1'b0;
    tick();
    check("t5_first", {1'b0, b0.data_out}, 8'h2D);
    ack0();
    tick();
    tick();
    drive0(7'h2D);
    tick();
    b0.in_valid = 1'b0;
    tick();
`ifdef RADIO_WRITE_DEDUP_EN
    check("t5_dup_dv",   {7'b0, b0.data_valid}, 8'd0);
    check("t5_dup_on",   {7'b0, b0.dup_drop},   8'd1);
    tick();
    check("t5_dup_off",  {7'b0, b0.dup_drop},   8'd0);
    check("t5_dup_idle", {7'b0, b0.busy},       8'd0);
`else
    check("t5_resend_dv", {7'b0, b0.data_valid}, 8'd1);
    check("t5_no_dup",    {7'b0, b0.dup_drop},   8'd0);
    ack0();
    tick();
    tick();
`endif
    drive0(7'h2E);
    tick();
    b0.in_valid = 1'b0;
    tick();
    check("t5_next_dv",   {7'b0, b0.data_valid}, 8'd1);
    check("t5_next_dout", {1'b0, b0.data_out},   8'h2E);
    check("t5_next_dup",  {7'b0, b0.dup_drop},   8'd0);
    ack0();

    // GAP_CYCLES=0: second packet one IDLE cycle after the first ack edge
    drive1(7'h31);
    tick();
    drive1(7'h32);
    tick();
    b1.in_valid = 1'b0;
    check("t6_dv1",   {7'b0, b1.data_valid}, 8'd1);
    check("t6_dout1", {1'b0, b1.data_out},   8'h31);
    b1.data_ack = 1'b1;
    tick();
    b1.data_ack = 1'b0;
    check("t6_idle_dv", {7'b0, b1.data_valid}, 8'd0);
    check("t6_busy",    {7'b0, b1.busy},       8'd1);
    tick();
    check("t6_dv2",   {7'b0, b1.data_valid}, 8'd1);
    check("t6_dout2", {1'b0, b1.data_out},   8'h32);
    b1.data_ack = 1'b1;
    tick();
    b1.data_ack = 1'b0;
    check("t6_end_dv",   {7'b0, b1.data_valid}, 8'd0);
    check("t6_end_busy", {7'b0, b1.busy},       8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/radio_write.md
RADIO_WRITE -- requirements
Module: radio_write

Interface
REQ-001 Parameter GAP_CYCLES, default 2: idle cycles enforced between consecutive packets (0 allowed).
REQ-002 Parameter TIMEOUT, default 255: max cycles DATA_VALID is held awaiting DATA_ACK (1..255).
REQ-003 Parameter FIFO_DEPTH, default 4: update queue depth (power of two, 2..16).
REQ-004 CLOCK  input  1  single clock; all state on rising edge.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 IN_X  input  3  maze cell X coordinate.
REQ-007 IN_Y  input  2  maze cell Y coordinate.
REQ-008 IN_VALUE  input  2  cell value.
REQ-009 IN_VALID  input  1  update offered this cycle.
REQ-010 IN_READY  output  1  queue can accept; equals not-full.
REQ-011 DATA_OUT  output  7  packet {X[2:0], Y[1:0], VALUE[1:0]}, MSB first field order.
REQ-012 DATA_VALID  output  1  DATA_OUT valid, held until ack or timeout.
REQ-013 DATA_ACK  input  1  radio side consumed DATA_OUT.
REQ-014 TX_FAIL  output  1  one-cycle pulse on timeout abort.
REQ-015 DUP_DROP  output  1  one-cycle pulse on duplicate discard (macro only; tied 0 otherwise).
REQ-016 BUSY  output  1  high when state is not IDLE or queue non-empty.

Function
REQ-017 Push occurs on an edge with IN_VALID and IN_READY both high; IN_VALID with IN_READY low is ignored (update lost, no flag).
REQ-018 IN_READY is not pop-aware: full queue rejects push even on a cycle the queue pops.
REQ-019 Simultaneous push and pop on a non-full, non-empty queue leaves count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-020 FSM states: IDLE, SEND, GAP.
REQ-021 IDLE with queue non-empty: pop head at the edge, register packet onto DATA_OUT, go SEND; DATA_VALID high from that edge.
REQ-022 Latency: update pushed at edge k into empty queue in IDLE -> DATA_VALID high after edge k+1.
REQ-023 SEND: DATA_OUT and DATA_VALID stable; wait counter increments each cycle.
REQ-024 SEND with DATA_ACK high at an edge -> GAP, DATA_VALID low after that edge; ack in the same cycle as timeout expiry counts as success.
REQ-025 SEND with wait counter reaching TIMEOUT and no ack -> GAP, DATA_VALID low, TX_FAIL pulses one cycle; packet is not retried.
REQ-026 DATA_ACK outside SEND is ignored.
REQ-027 GAP lasts exactly GAP_CYCLES cycles then IDLE; GAP_CYCLES=0 makes SEND go directly to IDLE.
REQ-028 DATA_OUT retains last packet value when DATA_VALID low.

Reset
REQ-029 RESET low asynchronously forces IDLE, empties queue, clears counters, DATA_OUT=0, DATA_VALID=0, TX_FAIL=0, DUP_DROP=0, BUSY=0, IN_READY=1.
REQ-030 Reset mid-SEND aborts the packet with no TX_FAIL pulse; queued updates are discarded.
REQ-031 Exit from reset is synchronous to CLOCK; first push accepted on the first edge with RESET high.

Configuration
REQ-032 Macro RADIO_WRITE_DEDUP_EN defined: block keeps last acked packet plus valid flag (cleared on reset); a popped packet equal to it is discarded in IDLE, DUP_DROP pulses, no SEND/GAP, state stays IDLE.
REQ-033 Timed-out packets never update the last-acked register.
REQ-034 Macro undefined: every popped packet is sent; DUP_DROP tied 0; no last-packet storage.

Verification
REQ-035 Single update X=5,Y=2,VALUE=3 pushed at edge k, ack one cycle later -> DATA_OUT=7'b1011011, DATA_VALID high after k+1, low after ack edge, IN_READY stays 1.
REQ-036 Push 5 updates back-to-back with DATA_ACK held low, FIFO_DEPTH=4 -> first enters SEND, next 4 fill queue, IN_READY low; sixth push rejected.
REQ-037 No ack, TIMEOUT=8 -> DATA_VALID high exactly 8 cycles, TX_FAIL one-cycle pulse, then GAP_CYCLES=2 idle cycles before next DATA_VALID.
REQ-038 Assert RESET low during SEND with 3 queued -> DATA_VALID=0 immediately (asynchronous), queue empty, no TX_FAIL, BUSY=0.
REQ-039 With RADIO_WRITE_DEDUP_EN: send and ack 7'h2D, then push 7'h2D again -> no DATA_VALID, DUP_DROP pulses once; push 7'h2E -> sent normally.
REQ-040 GAP_CYCLES=0, two queued, ack immediately -> second DATA_VALID rises on the edge after the first ack edge's IDLE cycle.
